// File: rtl/img_bank_writer_pkg.sv
// img_bank_writer_pkg
//   Shared constants and types for the ping-pong image bank writer.
//   IMG_WIDTH   : default pixel word width in bits
//   FRAME_WORDS : default words per image (32x32)
//   ADDR_W      : SRAM word address width
//   state_t     : one-hot writer FSM state encoding
package img_bank_writer_pkg;

    localparam int IMG_WIDTH   = 16;
    localparam int FRAME_WORDS = 1024;
    localparam int ADDR_W      = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        FILL1 = 3'b010,
        FILL2 = 3'b100
    } state_t;

endpackage

// File: rtl/img_bank_writer.sv
// img_bank_writer
//   Streams ISP pixel words into two SRAM banks in strict alternation
//   (1,2,1,2...). A bank is filled only when the fetch controller requests
//   it and it does not already hold a complete image; its full flag clears
//   on a rising edge of that bank's request.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   pix_data/pix_valid        input pixel stream
//   pix_ready                 high while filling a bank
//   img_request1/2            bank request from the layer-1 fetch controller
//   sram_en1/2, sram_wr1/2    active-low chip select / write enable per bank
//   sram_addr, sram_dout      shared write address / data (registered)
//   pre_sram_full1/2          bank holds a complete image
//   frame_cnt                 completed frame counter (wraps)
//
// Build option
//   FRAME_SOF_EN : adds pix_sof input and sticky sof_err output. A word
//                  marked SOF mid-frame realigns the frame to address 0;
//                  unmarked words at address 0 are accepted and dropped.
module img_bank_writer #(
    parameter int IMG_WIDTH   = img_bank_writer_pkg::IMG_WIDTH,
    parameter int FRAME_WORDS = img_bank_writer_pkg::FRAME_WORDS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [IMG_WIDTH-1:0]                   pix_data,
    input  logic                                   pix_valid,
`ifdef FRAME_SOF_EN
    input  logic                                   pix_sof,
    output logic                                   sof_err,
`endif
    output logic                                   pix_ready,
    input  logic                                   img_request1,
    input  logic                                   img_request2,
    output logic                                   sram_en1,
    output logic                                   sram_wr1,
    output logic                                   sram_en2,
    output logic                                   sram_wr2,
    output logic [img_bank_writer_pkg::ADDR_W-1:0] sram_addr,
    output logic [IMG_WIDTH-1:0]                   sram_dout,
    output logic                                   pre_sram_full1,
    output logic                                   pre_sram_full2,
    output logic [7:0]                             frame_cnt
);

    import img_bank_writer_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(FRAME_WORDS - 1);

    state_t            state, state_nx;
    logic              next_bank;      // 0: bank 1 is next, 1: bank 2
    logic [ADDR_W-1:0] count;
    logic              req1_d, req2_d;
    logic              last_d1, last_d2;

    logic              accept;         // handshake this cycle
    logic              wr_mem;         // accepted word actually goes to SRAM
    logic              realign;
    logic              drop;
    logic              last;
    logic              req1_rise, req2_rise;

    assign pix_ready = (state == FILL1) || (state == FILL2);
    assign accept    = pix_valid && pix_ready;

`ifdef FRAME_SOF_EN
    assign realign = accept && pix_sof && (count != '0);
    assign drop    = accept && !pix_sof && (count == '0);
`else
    assign realign = 1'b0;
    assign drop    = 1'b0;
`endif

    assign wr_mem = accept && !drop;
    // A realigned word restarts the frame, so it can never be the last one.
    assign last   = wr_mem && !realign && (count == LAST_CNT);

    // Request edge registers reset high so a request already asserted at
    // reset release is not seen as a new edge.
    assign req1_rise = img_request1 && !req1_d;
    assign req2_rise = img_request2 && !req2_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (!next_bank && img_request1 && !pre_sram_full1)
                    state_nx = FILL1;
                else if (next_bank && img_request2 && !pre_sram_full2)
                    state_nx = FILL2;
            end
            FILL1, FILL2: begin
                if (last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_bank      <= 1'b0;
            count          <= '0;
            frame_cnt      <= '0;
            req1_d         <= 1'b1;
            req2_d         <= 1'b1;
            last_d1        <= 1'b0;
            last_d2        <= 1'b0;
            pre_sram_full1 <= 1'b0;
            pre_sram_full2 <= 1'b0;
            sram_en1       <= 1'b1;
            sram_wr1       <= 1'b1;
            sram_en2       <= 1'b1;
            sram_wr2       <= 1'b1;
            sram_addr      <= '0;
            sram_dout      <= '0;
        end else begin
            req1_d <= img_request1;
            req2_d <= img_request2;

            // Strobes follow the accepted write by exactly one cycle.
            sram_en1 <= !(wr_mem && state == FILL1);
            sram_wr1 <= !(wr_mem && state == FILL1);
            sram_en2 <= !(wr_mem && state == FILL2);
            sram_wr2 <= !(wr_mem && state == FILL2);
            if (wr_mem) begin
                sram_addr <= realign ? '0 : count;
                sram_dout <= pix_data;
            end

            if (state == IDLE || last) count <= '0;
            else if (realign)          count <= ADDR_W'(1);
            else if (wr_mem)           count <= count + 1'b1;

            if (last) begin
                next_bank <= !next_bank;
                frame_cnt <= frame_cnt + 8'd1;
            end

            // Full is raised one cycle after the last strobe is on the bus.
            last_d1 <= last && (state == FILL1);
            last_d2 <= last && (state == FILL2);

            if (last_d1)        pre_sram_full1 <= 1'b1;
            else if (req1_rise) pre_sram_full1 <= 1'b0;
            if (last_d2)        pre_sram_full2 <= 1'b1;
            else if (req2_rise) pre_sram_full2 <= 1'b0;
        end
    end

`ifdef FRAME_SOF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         sof_err <= 1'b0;
        else if (realign) sof_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_img_bank_writer.sv
// tb_img_bank_writer
//   Directed bench for img_bank_writer: bank alternation, full flags,
//   request-edge clear, stalled streaming, mid-fill reset and (with
//   FRAME_SOF_EN) SOF realignment. Inputs change and outputs are sampled
//   on the falling clock edge.
module tb_img_bank_writer;

    localparam int W  = 16;
    localparam int FW = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic          img_request1 = 1'b0;
    logic          img_request2 = 1'b0;
    logic          sram_en1, sram_wr1, sram_en2, sram_wr2;
    logic [9:0]    sram_addr;
    logic [W-1:0]  sram_dout;
    logic          pre_sram_full1, pre_sram_full2;
    logic [7:0]    frame_cnt;
`ifdef FRAME_SOF_EN
    logic          pix_sof = 1'b0;
    logic          sof_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    img_bank_writer #(.IMG_WIDTH(W), .FRAME_WORDS(FW)) dut (
        .clk            (clk),
        .rst            (rst),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
`ifdef FRAME_SOF_EN
        .pix_sof        (pix_sof),
        .sof_err        (sof_err),
`endif
        .pix_ready      (pix_ready),
        .img_request1   (img_request1),
        .img_request2   (img_request2),
        .sram_en1       (sram_en1),
        .sram_wr1       (sram_wr1),
        .sram_en2       (sram_en2),
        .sram_wr2       (sram_wr2),
        .sram_addr      (sram_addr),
        .sram_dout      (sram_dout),
        .pre_sram_full1 (pre_sram_full1),
        .pre_sram_full2 (pre_sram_full2),
        .frame_cnt      (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe for the word accepted in the previous cycle, or all strobes idle.
    task automatic chk_strobe(input int bank, input logic pend,
                              input logic [9:0] pa, input logic [W-1:0] pd);
        if (pend)
            chk("strobe", {sram_en1, sram_wr1, sram_en2, sram_wr2, sram_addr, sram_dout},
                {(bank == 1) ? 4'b0011 : 4'b1100, pa, pd});
        else
            chk("idle_strobe", {sram_en1, sram_wr1, sram_en2, sram_wr2}, 4'b1111);
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready",   pix_ready, 1'b0);
        chk("rst_strobes", {sram_en1, sram_wr1, sram_en2, sram_wr2}, 4'b1111);
        chk("rst_addr",    sram_addr, 10'd0);
        chk("rst_dout",    sram_dout, 16'd0);
        chk("rst_full",    {pre_sram_full1, pre_sram_full2}, 2'b00);
        chk("rst_frames",  frame_cnt, 8'd0);
`ifdef FRAME_SOF_EN
        chk("rst_sof_err", sof_err, 1'b0);
`endif
    endtask

    // Streams nwords words with data = word index, valid on 1 of (gap+1)
    // cycles. Addresses are the word index, or restart at 0 from sof_at.
    task automatic stream(input int bank, input int nwords, input int gap, input int sof_at);
        int             sent;
        int             cyc;
        logic           pend;
        logic [9:0]     pa;
        logic [W-1:0]   pd;
        sent = 0;
        cyc  = 0;
        pend = 1'b0;
        pa   = '0;
        pd   = '0;
        while (sent < nwords && cyc < 20000) begin
            @(negedge clk);
            chk_strobe(bank, pend, pa, pd);
            pend      = 1'b0;
            pix_valid = ((cyc % (gap + 1)) == 0);
            pix_data  = W'(sent);
`ifdef FRAME_SOF_EN
            pix_sof   = (sent == 0) || (sent == sof_at);
`endif
            if (pix_valid && pix_ready) begin
                pend = 1'b1;
                pa   = (sof_at >= 0 && sent >= sof_at) ? 10'(sent - sof_at) : 10'(sent);
                pd   = W'(sent);
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        chk_strobe(bank, pend, pa, pd);
        pix_valid = 1'b0;
        chk("stream_done", 32'(sent), 32'(nwords));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst = 1'b1;
        img_request1 = 1'b1;
        img_request2 = 1'b1;

        // Bank 1 fill, data = address
        stream(1, FW, 0, -1);
        chk("b1_full_lag", pre_sram_full1, 1'b0);
        chk("b1_frames",   frame_cnt, 8'd1);
        img_request1 = 1'b0;
        @(negedge clk);
        chk("b1_full", pre_sram_full1, 1'b1);

        // Bank 2 fill
        stream(2, FW, 0, -1);
        chk("b2_full_lag", pre_sram_full2, 1'b0);
        chk("b2_frames",   frame_cnt, 8'd2);
        @(negedge clk);
        chk("b2_full", pre_sram_full2, 1'b1);

        // Both full, request 1 low: nothing consumed
        pix_valid = 1'b1;
        pix_data  = 16'hBEEF;
        repeat (4) begin
            @(negedge clk);
            chk("idle_ready",   pix_ready, 1'b0);
            chk("idle_strobes", {sram_en1, sram_wr1, sram_en2, sram_wr2}, 4'b1111);
        end
        pix_valid = 1'b0;

        // Request 1 rising edge clears full1, FILL1 follows a cycle later
        img_request1 = 1'b1;
        @(negedge clk);
        chk("clr_full1",   pre_sram_full1, 1'b0);
        chk("clr_ready0",  pix_ready, 1'b0);
        chk("keep_full2",  pre_sram_full2, 1'b1);
        @(negedge clk);
        chk("fill1_ready", pix_ready, 1'b1);

        // Stalled stream, valid 1 of 3 cycles
        stream(1, FW, 2, -1);
        chk("gap_frames", frame_cnt, 8'd3);
        @(negedge clk);
        chk("gap_full1", pre_sram_full1, 1'b1);
        chk("gap_ready", pix_ready, 1'b0);

        // Reset, partial fill to word 500, reset again
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        stream(1, 500, 0, -1);
        rst = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst = 1'b1;
        chk("post_rst_full", {pre_sram_full1, pre_sram_full2}, 2'b00);
        stream(1, FW, 0, -1);
        chk("restart_frames", frame_cnt, 8'd1);
        @(negedge clk);
        chk("restart_full", {pre_sram_full1, pre_sram_full2}, 2'b10);

`ifdef FRAME_SOF_EN
        // SOF at word 300 realigns to address 0 on bank 2
        chk("sof_err_pre", sof_err, 1'b0);
        stream(2, 300 + FW, 0, 300);
        chk("sof_err",    sof_err, 1'b1);
        chk("sof_frames", frame_cnt, 8'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/img_bank_writer.md
IMG_BANK_WRITER -- requirements
Module: img_bank_writer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 16, pixel word width in bits.
REQ-002 SHALL have parameter FRAME_WORDS, default 1024, words per image (32x32).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 pix_data  input  IMG_WIDTH  pixel word from the ISP stream.
REQ-006 pix_valid  input  1  pix_data valid this cycle.
REQ-007 pix_ready  output  1  block accepts a word this cycle.
REQ-008 img_request1, img_request2  input  1 each  bank 1/2 free request from the layer-1 fetch controller; high means image requested.
REQ-009 sram_en1, sram_wr1, sram_en2, sram_wr2  output  1 each  bank 1/2 chip select and write enable, active-low.
REQ-010 sram_addr  output  10  write address, shared by both banks.
REQ-011 sram_dout  output  IMG_WIDTH  write data, shared by both banks.
REQ-012 pre_sram_full1, pre_sram_full2  output  1 each  bank holds a complete image.
REQ-013 frame_cnt  output  8  completed frames, wraps 255->0.

Function
REQ-014 SHALL implement the FSM states IDLE, FILL1 and FILL2.
REQ-015 SHALL hold a next_bank pointer, reset to bank 1, so that banks are filled in strict alternation 1,2,1,2.
REQ-016 IDLE->FILLn SHALL occur when next_bank==n, img_requestn==1 and pre_sram_fulln==0; otherwise the FSM stays in IDLE.
REQ-017 pix_ready SHALL be 1 only in FILL1/FILL2, as a combinational function of state.
REQ-018 A write SHALL occur on each cycle with pix_valid&&pix_ready.
REQ-019 On a write, the next cycle SHALL present sram_enn=0, sram_wrn=0, sram_addr=word count and sram_dout=pix_data, all registered with 1-cycle latency.
REQ-020 On a non-write cycle, both enables and write enables SHALL be 1 the next cycle.
REQ-021 The word counter SHALL start at 0 on entering FILLn and increment per write.
REQ-022 On the write with count==FRAME_WORDS-1, the counter SHALL reset to 0, the FSM SHALL go to IDLE, next_bank SHALL toggle and frame_cnt SHALL increment.
REQ-023 pre_sram_fulln SHALL go to 1 the cycle after the last write strobe is presented.
REQ-024 pre_sram_fulln SHALL clear to 0 on a 0->1 edge of img_requestn, detected with a registered delay of the input.
REQ-025 If set and clear of fulln coincide, set SHALL win.
REQ-026 pix_valid gaps SHALL stall the fill without losing the address position.
REQ-027 The block SHALL never write a bank whose full flag is 1.
REQ-028 Words presented while in IDLE SHALL NOT be consumed, because pix_ready==0.

Reset
REQ-029 rst low SHALL force state IDLE, next_bank=1, counter 0, frame_cnt 0, pre_sram_full1/2=0, sram_en1/2=1, sram_wr1/2=1, sram_addr=0, sram_dout=0, and request-edge registers to 1.
REQ-030 A reset asserted mid-fill SHALL discard the partial frame; no full flag is raised for it.

Configuration
REQ-031 SHALL use macro FRAME_SOF_EN.
REQ-032 When FRAME_SOF_EN is defined, an input pix_sof (1 bit, marks the first word of a frame) SHALL be added.
REQ-033 When FRAME_SOF_EN is defined and a write with pix_sof==1 occurs at count!=0, that word SHALL be written at address 0 and the count SHALL continue from 1.
REQ-034 When FRAME_SOF_EN is defined, output sof_err (sticky, cleared only by reset) SHALL be set by the realignment in REQ-033.
REQ-035 When FRAME_SOF_EN is defined, words with pix_sof==0 at count==0 SHALL be dropped (accepted, not written).
REQ-036 When FRAME_SOF_EN is undefined, neither port SHALL exist and position SHALL be purely count-based.

Structure
REQ-037 Shared package SHALL hold IMG_WIDTH, FRAME_WORDS, the address width (10) and FSM state encodings (one-hot, 3 bits).
REQ-038 SHALL be one flat module, no sub-modules; request edge detection is inline.

Verification
REQ-039 Reset, then both requests high, stream 1024 words with data=address -> bank 1 written with addr 0..1023, pre_sram_full1=1 one cycle after the last strobe, frame_cnt=1.
REQ-040 Continue streaming 1024 more words -> bank 2 filled, pre_sram_full2=1, and pix_ready=0 afterwards while img_request1 is still low.
REQ-041 Drop img_request1 then raise it -> pre_sram_full1 clears the cycle after the edge, and the FSM enters FILL1 on the next cycle.
REQ-042 Drive pix_valid 1-of-3 cycles -> 1024 writes, no address skips, latency of 1 cycle per strobe.
REQ-043 Assert rst at word 500 of a fill -> all outputs at reset values, the next fill restarts at bank 1 address 0, and no full flag is raised.
REQ-044 With FRAME_SOF_EN defined, pix_sof at word 300 -> that word written at address 0 and sof_err=1.
